hazard_scoreboard: RTL

//  Sequential hazard unit for the pipelined MIPS core, placed beside the D stage.

---
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard scoreboard: in-flight writer tracking, stall, forwarding selects, MD busy
module hazard_scoreboard #(
    parameter int NSTAGE  = 3,
    parameter int TW      = 2,
    parameter int SELW    = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_valid,
    input  logic [4:0]      d_rs,
    input  logic [4:0]      d_rt,
    input  logic [TW-1:0]   d_rs_use,
    input  logic [TW-1:0]   d_rt_use,
    input  logic [4:0]      d_tar,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_md_start,
    input  logic            d_md_div,
    input  logic            d_md_use,
    input  logic            flush,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic            md_busy
);

    localparam int MDW = $clog2(DIV_LAT + 1);

    logic [NSTAGE-1:0] r_v;
    logic [4:0]        r_tar  [NSTAGE];
    logic [TW-1:0]     r_tnew [NSTAGE];
    logic [MDW-1:0]    r_md_cnt;

    logic [4:0]        w_src  [2];
    logic [TW-1:0]     w_use  [2];
    logic              w_hit  [2];
    logic [TW-1:0]     w_tnew [2];
    logic [SELW-1:0]   w_idx  [2];
    logic              w_haz  [2];
    logic [SELW-1:0]   w_sel  [2];
    logic              w_md_stall;
    logic              w_issue;

    assign w_src[0] = d_rs;
    assign w_src[1] = d_rt;
    assign w_use[0] = d_rs_use;
    assign w_use[1] = d_rt_use;

    // Scan oldest to youngest so the youngest matching writer overrides older ones.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_hit[s]  = 1'b0;
            w_tnew[s] = '0;
            w_idx[s]  = '0;
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (w_src[s] != 5'd0 && r_v[k] && r_tar[k] == w_src[s]) begin
                    w_hit[s]  = 1'b1;
                    w_tnew[s] = r_tnew[k];
                    w_idx[s]  = SELW'(k + 1);
                end
            end
            w_haz[s] = w_hit[s] && (w_tnew[s] > w_use[s]);
            w_sel[s] = (w_hit[s] && w_tnew[s] == '0) ? w_idx[s] : '0;
        end
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_md_stall = d_md_use & md_busy;
    assign stall      = d_valid & (w_haz[0] | w_haz[1] | w_md_stall);
    assign w_issue    = d_valid & ~stall & ~flush;
    assign fwd_rs_sel = w_sel[0];
    assign fwd_rt_sel = w_sel[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v      <= '0;
            r_md_cnt <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                r_tar[k]  <= '0;
                r_tnew[k] <= '0;
            end
        end else begin
            r_v[0]    <= w_issue;
            r_tar[0]  <= w_issue ? d_tar  : 5'd0;
            r_tnew[0] <= w_issue ? d_tnew : '0;
            for (int k = 1; k < NSTAGE; k++) begin
                r_v[k]    <= r_v[k-1];
                r_tar[k]  <= r_tar[k-1];
                r_tnew[k] <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - TW'(1) : '0;
            end
            if (w_issue && d_md_start) begin
                r_md_cnt <= d_md_div ? MDW'(DIV_LAT) : MDW'(MUL_LAT);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - MDW'(1);
            end
        end
    end

endmodule
